task_manager_master: RTL and testbench

- Master (task-manager) end of the task in/out handshake; drives the byte stream a task block consumes and collects its 32-bit answer stream.
- A local loader fills an input byte buffer; `i_start` launches one transaction; answer words land in an answer buffer readable by the test/control logic.
- Checks answer length against the task's reported packet size and reports status.

---
 rtl/task_mgr_pkg.sv | 31 +++
 rtl/task_mgr_buf.sv | 44 ++++
 rtl/task_manager_master.sv | 270 +++++++++++++++++++++++++++
 tb/tb_task_manager_master.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_mgr_pkg.sv
// rtl/task_mgr_pkg.sv - shared types and constants for the task-manager master
//
// Purpose: FSM state enum, status bit positions, data widths and the
//          answer-size helper used by task_manager_master.
// Ports:   none (package)
package task_mgr_pkg;

   localparam int BYTE_W = 8;    // width of a byte sent to the task
   localparam int WORD_W = 32;   // width of an answer word
   localparam int SIZE_W = 12;   // width of the reported answer size

   // Bit positions inside the sticky status vector.
   localparam int ERR_TIMEOUT  = 0;
   localparam int ERR_OVERFLOW = 1;
   localparam int ERR_SIZE     = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND     = 3'd1,
      ST_WAIT_ANS = 3'd2,
      ST_RECV     = 3'd3,
      ST_DONE     = 3'd4,
      ST_ERROR    = 3'd5
   } state_t;

   // Bytes covered by a number of 32-bit words, wrapped to SIZE_W bits.
   function automatic logic [SIZE_W-1:0] words_to_bytes(input logic [SIZE_W-1:0] words);
      return words << 2;
   endfunction

endpackage

// File: rtl/task_mgr_buf.sv
// rtl/task_mgr_buf.sv - simple dual-port RAM with registered read
//
// Purpose: one write port and one read port; read data appears one cycle
//          after the address is presented. Contents are never cleared; only
//          the read register is reset.
// Ports:   i_clk, i_rst      clock, synchronous active-high reset (read reg)
//          i_we, i_waddr,    write enable / address / data
//          i_wdata
//          i_raddr, o_rdata  read address / registered read data
module task_mgr_buf #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Addresses beyond DEPTH exist when DEPTH is not a power of two; they are
   // ignored on write and read back as zero.
   always_ff @(posedge i_clk) begin
      if (i_we && (int'(i_waddr) < DEPTH)) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rdata <= '0;
      end else if (int'(i_raddr) < DEPTH) begin
         o_rdata <= mem[i_raddr];
      end else begin
         o_rdata <= '0;
      end
   end

endmodule

// File: rtl/task_manager_master.sv
// rtl/task_manager_master.sv - master end of the task byte-in / word-out handshake
//
// Purpose: streams a locally loaded byte packet to a task block, collects
//          its 32-bit answer words into a readable buffer and reports
//          timeout / overflow / size-mismatch status.
// Ports:   i_clk, i_rst                      clock, synchronous active-high reset
//          i_load_we/addr/data               input byte buffer loader
//          i_len, i_start                    packet length, start pulse
//          o_task_data/_valid/_last,         byte stream to the task
//          i_task_data_request
//          o_task_manager_ready,             answer word stream from the task
//          i_task_answer_ready/_data/_last,
//          i_task_answer_packet_size_in_bytes
//          i_rd_addr, o_rd_data              answer buffer read (1-cycle latency)
//          o_busy, o_done, o_error,          transaction status
//          o_answer_words
module task_manager_master
   import task_mgr_pkg::*;
#(
   parameter int NUM_BYTES_MAX    = 100,
   parameter int NUM_ANSWER_WORDS = 32,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic                                  i_load_we,
   input  logic [$clog2(NUM_BYTES_MAX)-1:0]      i_load_addr,
   input  logic [BYTE_W-1:0]                     i_load_data,
   input  logic [$clog2(NUM_BYTES_MAX+1)-1:0]    i_len,
   input  logic                                  i_start,
   output logic [BYTE_W-1:0]                     o_task_data,
   output logic                                  o_task_data_valid,
   output logic                                  o_task_data_last,
   input  logic                                  i_task_data_request,
   output logic                                  o_task_manager_ready,
   input  logic                                  i_task_answer_ready,
   input  logic [WORD_W-1:0]                     i_task_answer_data,
   input  logic                                  i_task_answer_data_last,
   input  logic [SIZE_W-1:0]                     i_task_answer_packet_size_in_bytes,
   input  logic [$clog2(NUM_ANSWER_WORDS)-1:0]   i_rd_addr,
   output logic [WORD_W-1:0]                     o_rd_data,
   output logic                                  o_busy,
   output logic                                  o_done,
   output logic [2:0]                            o_error,
   output logic [$clog2(NUM_ANSWER_WORDS+1)-1:0] o_answer_words
);

   localparam int LA    = $clog2(NUM_BYTES_MAX);
   localparam int LEN_W = $clog2(NUM_BYTES_MAX + 1);
   localparam int RA    = $clog2(NUM_ANSWER_WORDS);
   localparam int CW    = $clog2(NUM_ANSWER_WORDS + 1);
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(NUM_BYTES_MAX);
   localparam logic [CW-1:0]    WORDS_MAX = CW'(NUM_ANSWER_WORDS);
   localparam logic [TW-1:0]    IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t            state, state_next;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx_q;
   logic              last_q;
   logic [CW-1:0]     count_q;
   logic [SIZE_W-1:0] size_q;
   logic [2:0]        err_q;
   logic [TW-1:0]     idle_q;

   logic              busy;
   logic              xfer;
   logic              accept;
   logic              start_ok;
   logic              timeout_hit;
   logic              room;
   logic [CW-1:0]     count_inc;
   logic [SIZE_W-1:0] size_ref;
   logic              size_bad;
   logic [LEN_W-1:0]  in_raddr_full;
   logic [LA-1:0]     in_raddr;
   logic              in_we;
   logic              ans_we;

   // ------------------------------------------------------------------
   // Handshake qualifiers
   // ------------------------------------------------------------------
   assign busy     = (state == ST_SEND) || (state == ST_WAIT_ANS) || (state == ST_RECV);
   assign xfer     = (state == ST_SEND) && i_task_data_request;
   assign accept   = ((state == ST_WAIT_ANS) || (state == ST_RECV)) && i_task_answer_ready;
   assign start_ok = (i_len != '0) && (i_len <= LEN_MAX);

   // A wait state times out on the cycle that would be the TIMEOUT_CYCLES-th
   // consecutive cycle without a transfer or accept.
   assign timeout_hit = busy && !xfer && !accept && (idle_q == IDLE_LAST);

   // Once the answer buffer is full further words are dropped and the count
   // saturates, so the size check compares against what was actually stored.
   assign room      = (count_q < WORDS_MAX);
   assign count_inc = room ? count_q + CW'(1) : count_q;
   // The size is latched on the first word, so that word compares against
   // the live input rather than the not-yet-updated register.
   assign size_ref  = (state == ST_WAIT_ANS) ? i_task_answer_packet_size_in_bytes : size_q;
   assign size_bad  = (words_to_bytes(SIZE_W'(count_inc)) != size_ref);

   // ------------------------------------------------------------------
   // Input byte buffer. Its registered read output is the byte on the bus:
   // on a transfer the next index is fetched so a new byte is presented on
   // the following cycle; otherwise the current index is re-read, holding
   // the byte. Outside SEND index 0 is pre-read so SEND starts with buf[0].
   // ------------------------------------------------------------------
   always_comb begin
      in_raddr_full = '0;
      if (state == ST_SEND) begin
         in_raddr_full = (xfer && !last_q) ? idx_q + LEN_W'(1) : idx_q;
      end
   end

   assign in_raddr = in_raddr_full[LA-1:0];
   assign in_we    = i_load_we && !busy;

   task_mgr_buf #(
      .WIDTH (BYTE_W),
      .DEPTH (NUM_BYTES_MAX)
   ) u_in_buf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (in_we),
      .i_waddr (i_load_addr),
      .i_wdata (i_load_data),
      .i_raddr (in_raddr),
      .o_rdata (o_task_data)
   );

   // ------------------------------------------------------------------
   // Answer word buffer
   // ------------------------------------------------------------------
   assign ans_we = accept && room;

   task_mgr_buf #(
      .WIDTH (WORD_W),
      .DEPTH (NUM_ANSWER_WORDS)
   ) u_ans_buf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (ans_we),
      .i_waddr (count_q[RA-1:0]),
      .i_wdata (i_task_answer_data),
      .i_raddr (i_rd_addr),
      .o_rdata (o_rd_data)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               state_next = start_ok ? ST_SEND : ST_DONE;
            end
         end
         ST_SEND: begin
            if (timeout_hit) begin
               state_next = ST_ERROR;
            end else if (xfer && last_q) begin
               state_next = ST_WAIT_ANS;
            end
         end
         ST_WAIT_ANS: begin
            if (timeout_hit) begin
               state_next = ST_ERROR;
            end else if (accept) begin
               state_next = i_task_answer_data_last ? ST_DONE : ST_RECV;
            end
         end
         ST_RECV: begin
            if (timeout_hit) begin
               state_next = ST_ERROR;
            end else if (accept && i_task_answer_data_last) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         ST_ERROR: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         len_q   <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
         size_q  <= '0;
         err_q   <= '0;
         idle_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start && start_ok) begin
                  err_q   <= '0;
                  count_q <= '0;
                  len_q   <= i_len;
                  idx_q   <= '0;
                  last_q  <= (i_len == LEN_W'(1));
                  idle_q  <= '0;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  idle_q <= '0;
                  if (last_q) begin
                     last_q <= 1'b0;
                  end else begin
                     idx_q  <= idx_q + LEN_W'(1);
                     last_q <= (idx_q + LEN_W'(2) == len_q);
                  end
               end else if (timeout_hit) begin
                  err_q[ERR_TIMEOUT] <= 1'b1;
                  last_q             <= 1'b0;
               end else begin
                  idle_q <= idle_q + TW'(1);
               end
            end
            ST_WAIT_ANS, ST_RECV: begin
               if (accept) begin
                  idle_q  <= '0;
                  count_q <= count_inc;
                  if (!room) begin
                     err_q[ERR_OVERFLOW] <= 1'b1;
                  end
                  if (state == ST_WAIT_ANS) begin
                     size_q <= i_task_answer_packet_size_in_bytes;
                  end
                  if (i_task_answer_data_last && size_bad) begin
                     err_q[ERR_SIZE] <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  err_q[ERR_TIMEOUT] <= 1'b1;
               end else begin
                  idle_q <= idle_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs (all decoded from registers)
   // ------------------------------------------------------------------
   assign o_task_data_valid    = (state == ST_SEND);
   assign o_task_data_last     = last_q;
   assign o_task_manager_ready = (state == ST_WAIT_ANS) || (state == ST_RECV);
   assign o_busy               = busy;
   assign o_done               = (state == ST_DONE) || (state == ST_ERROR);
   assign o_error              = err_q;
   assign o_answer_words       = count_q;

endmodule

// File: tb/tb_task_manager_master.sv
// tb/tb_task_manager_master.sv - scoreboard bench for task_manager_master
module tb_task_manager_master;

   localparam int NB = 100;
   localparam int NA = 4;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_load_we;
   logic [6:0]  i_load_addr;
   logic [7:0]  i_load_data;
   logic [6:0]  i_len;
   logic        i_start;
   logic [7:0]  o_task_data;
   logic        o_task_data_valid;
   logic        o_task_data_last;
   logic        i_task_data_request;
   logic        o_task_manager_ready;
   logic        i_task_answer_ready;
   logic [31:0] i_task_answer_data;
   logic        i_task_answer_data_last;
   logic [11:0] i_task_answer_packet_size_in_bytes;
   logic [1:0]  i_rd_addr;
   logic [31:0] o_rd_data;
   logic        o_busy;
   logic        o_done;
   logic [2:0]  o_error;
   logic [2:0]  o_answer_words;

   always #5 clk = ~clk;

   task_manager_master #(
      .NUM_BYTES_MAX    (NB),
      .NUM_ANSWER_WORDS (NA),
      .TIMEOUT_CYCLES   (TO)
   ) dut (
      .i_clk                              (clk),
      .i_rst                              (i_rst),
      .i_load_we                          (i_load_we),
      .i_load_addr                        (i_load_addr),
      .i_load_data                        (i_load_data),
      .i_len                              (i_len),
      .i_start                            (i_start),
      .o_task_data                        (o_task_data),
      .o_task_data_valid                  (o_task_data_valid),
      .o_task_data_last                   (o_task_data_last),
      .i_task_data_request                (i_task_data_request),
      .o_task_manager_ready               (o_task_manager_ready),
      .i_task_answer_ready                (i_task_answer_ready),
      .i_task_answer_data                 (i_task_answer_data),
      .i_task_answer_data_last            (i_task_answer_data_last),
      .i_task_answer_packet_size_in_bytes (i_task_answer_packet_size_in_bytes),
      .i_rd_addr                          (i_rd_addr),
      .o_rd_data                          (o_rd_data),
      .o_busy                             (o_busy),
      .o_done                             (o_done),
      .o_error                            (o_error),
      .o_answer_words                     (o_answer_words)
   );

   typedef struct {
      logic [2:0] err;
      int         words;
   } res_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [7:0]  mem_model [NB];
   logic [31:0] ans_model [NA];
   logic [8:0]  exp_byte_q [$];
   res_t        exp_res_q [$];
   int          xfer_cnt, first_xfer, last_xfer;
   logic [2:0]  prev_err   = '0;
   int          prev_words = 0;

   logic        p_valid = 1'b0, p_req = 1'b0, p_rst = 1'b1, p_last = 1'b0;
   logic [7:0]  p_data  = '0;
   logic [8:0]  e_byte;
   res_t        e_res;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Byte-stream monitor: every transfer pops the next expected byte; while
   // request is low the presented byte must hold.
   always @(negedge clk) begin
      if (!i_rst && o_task_data_valid && i_task_data_request) begin
         if (xfer_cnt == 0) first_xfer = cyc;
         last_xfer = cyc;
         xfer_cnt++;
         if (exp_byte_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", o_task_data);
         end else begin
            e_byte = exp_byte_q.pop_front();
            check("byte_data", 32'(o_task_data), 32'(e_byte[7:0]));
            check("byte_last", 32'(o_task_data_last), 32'(e_byte[8]));
         end
      end
      if (p_valid && !p_req && !p_rst && !o_done) begin
         check("hold_valid", 32'(o_task_data_valid), 32'd1);
         check("hold_data", 32'(o_task_data), 32'(p_data));
         check("hold_last", 32'(o_task_data_last), 32'(p_last));
      end
      p_valid = o_task_data_valid;
      p_req   = i_task_data_request;
      p_rst   = i_rst;
      p_data  = o_task_data;
      p_last  = o_task_data_last;
   end

   // Completion monitor
   always @(negedge clk) begin
      if (o_done) begin
         if (exp_res_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done pulse, expected none");
         end else begin
            e_res = exp_res_q.pop_front();
            check("done_error", 32'(o_error), 32'(e_res.err));
            check("done_words", 32'(o_answer_words), 32'(e_res.words));
            check("done_not_busy", 32'(o_busy), 32'd0);
         end
      end
   end

   task automatic load_byte(input int addr, input logic [7:0] data);
      @(posedge clk); #1;
      i_load_we   = 1'b1;
      i_load_addr = addr[6:0];
      i_load_data = data;
      mem_model[addr] = data;
      @(posedge clk); #1;
      i_load_we = 1'b0;
   endtask

   // mode: 0 request always high, 1 request pattern 1,0,0, 2 random, 3 never
   task automatic run_txn(input int len, input int mode, input int nwords, input logic [11:0] size);
      logic [31:0] words [$];
      res_t        r;
      bit          good, done_seen;
      int          stored, widx, n;
      good   = (len > 0) && (len <= NB);
      stored = (nwords > NA) ? NA : nwords;
      for (int i = 0; i < nwords; i++) words.push_back($urandom);
      if (good && mode != 3) begin
         for (int i = 0; i < len; i++) exp_byte_q.push_back({(i == len - 1), mem_model[i]});
      end
      if (!good) begin
         r.err   = prev_err;
         r.words = prev_words;
         stored  = 0;
      end else if (mode == 3) begin
         r.err   = 3'b001;
         r.words = 0;
         stored  = 0;
      end else begin
         r.err = '0;
         if (nwords > NA) r.err[1] = 1'b1;
         if (((stored * 4) % 4096) != int'(size)) r.err[2] = 1'b1;
         r.words = stored;
         for (int i = 0; i < stored; i++) ans_model[i] = words[i];
      end
      prev_err   = r.err;
      prev_words = r.words;
      exp_res_q.push_back(r);
      xfer_cnt = 0;

      @(posedge clk); #1;
      i_len   = len[6:0];
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      n = 0;
      widx = 0;
      done_seen = 0;
      while (!done_seen && n < 400) begin
         case (mode)
            0:       i_task_data_request = 1'b1;
            1:       i_task_data_request = (n % 3 == 0);
            2:       i_task_data_request = ($urandom_range(0, 3) != 0);
            default: i_task_data_request = 1'b0;
         endcase
         if (widx < nwords) begin
            i_task_answer_ready     = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_task_answer_data      = words[widx];
            i_task_answer_data_last = (widx == nwords - 1);
         end else begin
            i_task_answer_ready     = 1'b0;
            i_task_answer_data_last = 1'b0;
         end
         i_task_answer_packet_size_in_bytes = size;
         // Loads while busy must be ignored; a stray write would corrupt
         // later packets that reuse the model contents.
         i_load_we   = o_busy;
         i_load_addr = 7'($urandom_range(0, NB - 1));
         i_load_data = 8'($urandom);
         @(negedge clk);
         n++;
         if (o_task_manager_ready && i_task_answer_ready) widx++;
         if (o_done) done_seen = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      i_task_data_request     = 1'b0;
      i_task_answer_ready     = 1'b0;
      i_task_answer_data_last = 1'b0;
      i_load_we               = 1'b0;
      if (!done_seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL txn_done_budget: got no done in %0d cycles, expected done", n);
         exp_res_q.delete();
      end
      check("bytes_all_sent", 32'(exp_byte_q.size()), 32'd0);
      exp_byte_q.delete();
      if (!good) check("bad_len_latency", 32'(n), 32'd1);
      if (good && mode == 0) check("throughput", 32'(last_xfer - first_xfer), 32'(len - 1));
      if (good && mode == 3) begin
         check("timeout_cycles", 32'(n), 32'(TO + 1));
         check("valid_low_at_error", 32'(o_task_data_valid), 32'd0);
      end
      for (int i = 0; i < stored; i++) begin
         @(posedge clk); #1;
         i_rd_addr = 2'(i);
         @(posedge clk);
         @(negedge clk);
         check("answer_word", o_rd_data, ans_model[i]);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_load_we = 1'b0;
      i_load_addr = '0;
      i_load_data = '0;
      i_len = '0;
      i_start = 1'b0;
      i_task_data_request = 1'b0;
      i_task_answer_ready = 1'b0;
      i_task_answer_data = '0;
      i_task_answer_data_last = 1'b0;
      i_task_answer_packet_size_in_bytes = '0;
      i_rd_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(o_task_data_valid), 32'd0);
      check("rst_last", 32'(o_task_data_last), 32'd0);
      check("rst_data", 32'(o_task_data), 32'd0);
      check("rst_ready", 32'(o_task_manager_ready), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_error", 32'(o_error), 32'd0);
      check("rst_words", 32'(o_answer_words), 32'd0);
      check("rst_rd_data", o_rd_data, 32'd0);
      @(posedge clk); #1;
      i_rst = 1'b0;

      for (int i = 0; i < 5; i++) load_byte(i, 8'(i + 1));

      run_txn(5, 0, 2, 12'd8);    // clean two-word answer
      run_txn(5, 1, 2, 12'd8);    // request toggling 1,0,0
      run_txn(5, 0, 3, 12'd8);    // size mismatch
      run_txn(5, 0, 6, 12'd16);   // overflow only
      run_txn(5, 0, 6, 12'd24);   // overflow plus mismatch
      run_txn(3, 0, 1, 12'd4);    // single-word answer
      run_txn(5, 3, 2, 12'd8);    // timeout
      run_txn(1, 0, 1, 12'd4);    // one-byte packet, clean
      run_txn(0, 0, 0, 12'd0);    // zero length
      run_txn(101, 0, 0, 12'd0);  // too long

      // Reset after two of five bytes.
      exp_byte_q.push_back({1'b0, mem_model[0]});
      exp_byte_q.push_back({1'b0, mem_model[1]});
      @(posedge clk); #1;
      i_len   = 7'd5;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_task_data_request = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_task_data_request = 1'b0;
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(o_task_data_valid), 32'd0);
      check("midrst_busy", 32'(o_busy), 32'd0);
      check("midrst_bytes", 32'(exp_byte_q.size()), 32'd0);
      check("midrst_error", 32'(o_error), 32'd0);
      exp_byte_q.delete();
      prev_err   = '0;
      prev_words = 0;
      run_txn(5, 0, 2, 12'd8);

      for (int t = 0; t < 20; t++) begin
         int          len, nw;
         logic [11:0] sz;
         if (t % 2 == 0) begin
            for (int k = 0; k < 6; k++) load_byte($urandom_range(0, 23), 8'($urandom));
         end
         len = $urandom_range(1, 24);
         nw  = $urandom_range(1, 6);
         sz  = ($urandom_range(0, 1) == 1) ? 12'(((nw > NA) ? NA : nw) * 4) : 12'($urandom_range(0, 31));
         run_txn(len, $urandom_range(0, 2), nw, sz);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
